// File: rtl/ram_responder.sv
// Memory-side responder: simple dual-port array, write-first on same-address collision, saturating activity counters.
// Read data returns pRD_LAT enabled cycles after the strobe; no backpressure, every accepted read yields one oval.
module ram_responder #(
    parameter int pW      = 36,
    parameter int pA      = 10,
    parameter int pRD_LAT = 2,
    parameter int pCNT_W  = 16
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              iclk_ena,
    input  logic              iwrena,
    input  logic [pA-1:0]     iwr_adr,
    input  logic [pW-1:0]     idat,
    input  logic              irdena,
    input  logic [pA-1:0]     ird_adr,
    output logic              oval,
    output logic [pW-1:0]     odat,
    output logic [pA-1:0]     oadr,
    output logic              ocoll,
    output logic [pCNT_W-1:0] owr_cnt,
    output logic [pCNT_W-1:0] ord_cnt
);

    localparam int DEPTH = 1 << pA;

    generate
        if (pRD_LAT < 1 || pRD_LAT > 8) begin : g_bad_lat
            $error("ram_responder: pRD_LAT must be in 1..8");
        end
    endgenerate

    logic [pW-1:0] mem [DEPTH];

    logic          wr_acc;
    logic          rd_acc;
    logic          coll;
    logic [pW-1:0] rd_word;

    logic [pRD_LAT-1:0]          vld_d,  vld_q;
    logic [pRD_LAT-1:0]          coll_d, coll_q;
    logic [pRD_LAT-1:0][pW-1:0]  dat_d,  dat_q;
    logic [pRD_LAT-1:0][pA-1:0]  adr_d,  adr_q;
    logic [pCNT_W-1:0]           wr_cnt_d, wr_cnt_q;
    logic [pCNT_W-1:0]           rd_cnt_d, rd_cnt_q;

    always_comb begin
        wr_acc  = irst & iclk_ena & iwrena;
        rd_acc  = irst & iclk_ena & irdena;
        coll    = wr_acc & rd_acc & (iwr_adr == ird_adr);
        rd_word = coll ? idat : mem[ird_adr];
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge iclk) begin
        if (wr_acc) begin
            mem[iwr_adr] <= idat;
        end
    end

    // Payload stages only load behind a valid, so the last stage keeps the
    // previous response on its outputs while oval is low.
    always_comb begin
        vld_d    = vld_q;
        coll_d   = coll_q;
        dat_d    = dat_q;
        adr_d    = adr_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (iclk_ena) begin
            vld_d[0] = rd_acc;
            if (rd_acc) begin
                dat_d[0]  = rd_word;
                adr_d[0]  = ird_adr;
                coll_d[0] = coll;
            end
            for (int i = 1; i < pRD_LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i]  = dat_q[i-1];
                    adr_d[i]  = adr_q[i-1];
                    coll_d[i] = coll_q[i-1];
                end
            end
            if (wr_acc && (wr_cnt_q != '1)) begin
                wr_cnt_d = wr_cnt_q + pCNT_W'(1);
            end
            if (rd_acc && (rd_cnt_q != '1)) begin
                rd_cnt_d = rd_cnt_q + pCNT_W'(1);
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            vld_q    <= '0;
            coll_q   <= '0;
            dat_q    <= '0;
            adr_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            vld_q    <= vld_d;
            coll_q   <= coll_d;
            dat_q    <= dat_d;
            adr_q    <= adr_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign oval    = vld_q[pRD_LAT-1];
    assign odat    = dat_q[pRD_LAT-1];
    assign oadr    = adr_q[pRD_LAT-1];
    assign ocoll   = coll_q[pRD_LAT-1];
    assign owr_cnt = wr_cnt_q;
    assign ord_cnt = rd_cnt_q;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side end of the write/read-enable + address bus produced by the stream-to-RAM controller.
- Sinks the controller's write strobes (wrena, wr_adr, dat) into an internal 2**pA x pW simple dual-port array.
- Answers read strobes (rdena, rd_adr) with data after a fixed, parameterised latency.
- Also reports address collisions and keeps write/read activity counters for debug.

Parameters:
- pW, 36: data word width.
- pA, 10: address width; depth = 2**pA words.
- pRD_LAT, 2: read latency in enabled cycles; legal range 1..8.
- pCNT_W, 16: width of the activity counters.

Ports:
- iclk  in  1  clock.
- irst  in  1  reset; this reset is synchronous and active-low.
- iclk_ena  in  1  clock enable; block frozen when 0.
- iwrena  in  1  write strobe.
- iwr_adr  in  pA  write address.
- idat  in  pW  write data.
- irdena  in  1  read strobe.
- ird_adr  in  pA  read address.
- oval  out  1  read data valid.
- odat  out  pW  read data.
- oadr  out  pA  address of the returned word (echo of ird_adr).
- ocoll  out  1  returned word came from a same-cycle write collision.
- owr_cnt  out  pCNT_W  accepted writes, saturating.
- ord_cnt  out  pCNT_W  accepted reads, saturating.

Behaviour:
- Only one clock, iclk. Reset is synchronous and active-low: sampled on the iclk rising edge when irst=0. iclk_ena is ignored while reset is asserted.
- Reset values: oval=0, odat=0, oadr=0, ocoll=0, owr_cnt=0, ord_cnt=0. All pipeline valid bits are cleared. Array contents are NOT reset and keep their prior values.
- A strobe is accepted only on an edge with irst=1 and iclk_ena=1. With iclk_ena=0 nothing advances: array, pipeline, counters and all outputs hold. Latency is counted in enabled edges only.
- Write: accepted iwrena writes idat to mem[iwr_adr] on that edge.
- Read: accepted irdena at enabled edge N gives oval=1 with odat=mem[ird_adr], oadr=ird_adr and the matching ocoll after enabled edge N+pRD_LAT-1. With pRD_LAT=1 the output is registered directly.
  - oval is high for exactly one enabled cycle per accepted read.
  - Back-to-back reads give back-to-back oval.
  - Returned data is the memory value as of edge N; later writes do not affect an in-flight read.
- Collision: iwrena and irdena both accepted on the same edge with iwr_adr==ird_adr.
  - Write-first: the read returns the new idat, and ocoll=1 alongside that word's oval.
  - Different addresses: no collision; the read returns the old contents.
- When oval=0: odat, oadr and ocoll keep their last values. ocoll is meaningful only when oval=1.
- Counters: +1 per accepted write or read. They saturate at 2**pCNT_W-1 and never wrap. Both may increment on the same edge.
- Reset mid-operation: in-flight reads are discarded, with no oval after reset. Writes accepted before reset persist.
- No flow control: every accepted read produces exactly one response, because the consumer is always ready.
- Out-of-range addresses are impossible, since the depth is the full 2**pA.
- pRD_LAT outside 1..8 is a compile-time error (elaboration assertion).

Test Plan:
- Write 0x0_0000_00AB to addr 5, idle 3 cycles, then read addr 5 (pRD_LAT=2) -> oval=1 exactly 2 enabled edges after the read edge, odat=0x0_0000_00AB, oadr=5, ocoll=0.
- Same-edge write of 0x1_2345_6789 to addr 7 and read of addr 7, where addr 7 held 0x0 -> returned odat=0x1_2345_6789, ocoll=1. Repeat with read addr 8 -> odat=old mem[8], ocoll=0.
- Burst of 16 consecutive reads of addrs 0..15 after filling them with data=addr*3 -> 16 contiguous oval cycles, odat=addr*3 in order.
- Read accepted, then iclk_ena=0 for 4 cycles, then 1 -> oval arrives after 2 enabled edges; all outputs hold during the gap; counters unchanged while gated.
- Read issued, irst=0 on the next edge -> no oval ever appears for that read; owr_cnt=ord_cnt=0; data written earlier is still readable after reset.
- pCNT_W=4, 20 writes and 20 reads -> owr_cnt=ord_cnt=15 and stays at 15 (saturated); repeat all tests with pRD_LAT=1 and 8.
